truth_table_characterizer: RTL and testbench

//   Inverse of a truth-table gate: sweeps all 2^N_IN input combinations into a

---
 rtl/truth_table_characterizer.sv | 134 +++++++++++++
 tb/tb_truth_table_characterizer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_characterizer.sv
// truth_table_characterizer
// Sweeps every input combination of a combinational gate under test, samples
// the gate output through a two-flop synchronizer and rebuilds the gate's
// truth-table code. Combination 0 lands in the MSB of the code. A completed
// sweep updates result/match and pulses done for one cycle. abort drops a
// sweep in progress without touching the last result.
//
// Timing (start accepted on edge E0):
//   - Each combination k holds dut_in=k for SETTLE_CYCLES cycles in SETTLE and
//     one SAMPLE cycle, i.e. SETTLE_CYCLES+1 cycles per combination.
//   - The last SAMPLE moves to DONE. The DONE cycle registers result/match and
//     raises done, so done is high just after edge
//     E0 + 2^N_IN*(SETTLE_CYCLES+1) + 1.
//   - dut_in keeps the last combination after a completed sweep and returns to
//     0 on the next start. It also returns to 0 on abort or reset.
module truth_table_characterizer #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [(1<<N_IN)-1:0]  expected,
    input  logic                  dut_out,
    output logic [N_IN-1:0]       dut_in,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  result,
    output logic                  match
);

    localparam int CODE_W = 1 << N_IN;
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  IDX_LAST = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [N_IN-1:0]   idx;
    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] shadow;
    logic [CODE_W-1:0] expected_q;
    logic [1:0]        sync_q;

    // Two-flop synchronizer for the gate output, which is not timed against clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], dut_out};
        end
    end

    // Sweep controller: drives combinations, builds the code and registers all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            expected_q <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            match      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SETTLE;
                        idx        <= '0;
                        cnt        <= '0;
                        dut_in     <= '0;
                        busy       <= 1'b1;
                        expected_q <= expected;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        dut_in <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SAMPLE: begin
                    if (abort) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        dut_in <= '0;
                    end else begin
                        // ~idx equals 2^N_IN-1-idx, so combination 0 fills the MSB.
                        shadow[~idx] <= sync_q[1];
                        if (idx == IDX_LAST) begin
                            state <= DONE;
                        end else begin
                            idx    <= idx + 1'b1;
                            dut_in <= idx + 1'b1;
                            cnt    <= '0;
                            state  <= SETTLE;
                        end
                    end
                end

                DONE: begin
                    result <= shadow;
                    match  <= (shadow == expected_q);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_characterizer.sv
// tb_truth_table_characterizer
// Three characterizer builds with gate models:
//   u1: N_IN=3, SETTLE_CYCLES=4, selectable 0xA7 / constant-0 / constant-1 gate
//   u2: N_IN=2, SETTLE_CYCLES=4, XOR gate
//   u3: N_IN=3, SETTLE_CYCLES=3, 0xA7 gate with one cycle of output delay
// Expected completions are queued at start time. One monitor per build pops
// them when done fires and compares result, match and arrival cycle.
module tb_truth_table_characterizer;

    localparam int LAT1 = 8 * (4 + 1) + 1;
    localparam int LAT2 = 4 * (4 + 1) + 1;
    localparam int LAT3 = 8 * (3 + 1) + 1;

    typedef struct {
        logic [7:0] res;
        logic       mat;
        int         when;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [7:0] expected1 = 8'h00;
    logic       dut_out1;
    logic [2:0] dut_in1;
    logic       busy1, done1, match1;
    logic [7:0] result1;
    int         gate_sel = 0;

    logic       start2 = 1'b0;
    logic [3:0] expected2 = 4'h0;
    logic       dut_out2;
    logic [1:0] dut_in2;
    logic       busy2, done2, match2;
    logic [3:0] result2;

    logic       start3 = 1'b0;
    logic [7:0] expected3 = 8'h00;
    logic       dut_out3;
    logic [2:0] dut_in3;
    logic       busy3, done3, match3;
    logic [7:0] result3;

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Hand-written gate: 1 at 000, 010, 101, 110, 111.
    function automatic logic gate_a7(input logic [2:0] c);
        case (c)
            3'd0, 3'd2, 3'd5, 3'd6, 3'd7: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    assign dut_out1 = (gate_sel == 0) ? gate_a7(dut_in1) : (gate_sel == 2);
    assign dut_out2 = dut_in2[1] ^ dut_in2[0];

    // Gate model with one cycle of output delay.
    always @(posedge clk) dut_out3 <= gate_a7(dut_in3);

    truth_table_characterizer #(.N_IN(3), .SETTLE_CYCLES(4)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(expected1),
        .dut_out(dut_out1), .dut_in(dut_in1), .busy(busy1), .done(done1),
        .result(result1), .match(match1));

    truth_table_characterizer #(.N_IN(2), .SETTLE_CYCLES(4)) u2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .expected(expected2),
        .dut_out(dut_out2), .dut_in(dut_in2), .busy(busy2), .done(done2),
        .result(result2), .match(match2));

    truth_table_characterizer #(.N_IN(3), .SETTLE_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .expected(expected3),
        .dut_out(dut_out3), .dut_in(dut_in3), .busy(busy3), .done(done3),
        .result(result3), .match(match3));

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, required, cycle);
        end
    endtask

    // Issue a sweep on u1; track=1 queues the expected completion.
    task automatic applyStimulus(input int sel, input logic [7:0] code,
                                 input logic [7:0] res, input logic mat,
                                 input bit track, input bit with_abort);
        exp_t e;
        @(negedge clk);
        gate_sel  = sel;
        expected1 = code;
        start1    = 1'b1;
        abort1    = with_abort;
        if (track) begin
            e.res  = res;
            e.mat  = mat;
            e.when = cycle + 1 + LAT1;
            q1.push_back(e);
        end
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while ((q1.size() + q2.size() + q3.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("pending completions", 32'(q1.size() + q2.size() + q3.size()), 32'd0);
    endtask

    // Scoreboard monitor for u1.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done1) begin
            if (q1.size() == 0) begin
                checkOutput("u1 spurious done", 32'(done1), 32'd0);
            end else begin
                e = q1.pop_front();
                checkOutput("u1 result", 32'(result1), 32'(e.res));
                checkOutput("u1 match", 32'(match1), 32'(e.mat));
                checkOutput("u1 done cycle", 32'(cycle), 32'(e.when));
            end
        end
    end

    // Scoreboard monitor for u2.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done2) begin
            if (q2.size() == 0) begin
                checkOutput("u2 spurious done", 32'(done2), 32'd0);
            end else begin
                e = q2.pop_front();
                checkOutput("u2 result", 32'(result2), 32'(e.res));
                checkOutput("u2 match", 32'(match2), 32'(e.mat));
                checkOutput("u2 done cycle", 32'(cycle), 32'(e.when));
            end
        end
    end

    // Scoreboard monitor for u3.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done3) begin
            if (q3.size() == 0) begin
                checkOutput("u3 spurious done", 32'(done3), 32'd0);
            end else begin
                e = q3.pop_front();
                checkOutput("u3 result", 32'(result3), 32'(e.res));
                checkOutput("u3 match", 32'(match3), 32'(e.mat));
                checkOutput("u3 done cycle", 32'(cycle), 32'(e.when));
            end
        end
    end

    initial begin
        exp_t e;

        // Reset state
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset dut_in", 32'(dut_in1), 32'd0);
        checkOutput("reset busy", 32'(busy1), 32'd0);
        checkOutput("reset done", 32'(done1), 32'd0);
        checkOutput("reset result", 32'(result1), 32'd0);
        checkOutput("reset match", 32'(match1), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1) 0xA7 gate, dut_in walks 0..7
        applyStimulus(0, 8'hA7, 8'hA7, 1'b1, 1'b1, 1'b0);
        checkOutput("t1 busy", 32'(busy1), 32'd1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("t1 dut_in step", 32'(dut_in1), 32'(k));
            repeat (5) @(negedge clk);
        end
        waitDone(100);
        checkOutput("t1 busy after done", 32'(busy1), 32'd0);

        // 2) constant-0 against 0xFF, then constant-1
        applyStimulus(1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
        waitDone(100);
        applyStimulus(2, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        waitDone(100);
        repeat (10) @(negedge clk);
        checkOutput("t2 result holds", 32'(result1), 32'hFF);
        checkOutput("t2 match holds", 32'(match1), 32'd1);

        // 3) start re-pulsed at cycles 5 and 20 of a sweep is ignored
        applyStimulus(0, 8'hA7, 8'hA7, 1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (14) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checkOutput("t3 busy mid-sweep", 32'(busy1), 32'd1);
        waitDone(100);
        repeat (50) @(negedge clk);
        checkOutput("t3 idle after sweep", 32'(busy1), 32'd0);

        // 4) abort at cycle 12, result kept; restart with start+abort together
        applyStimulus(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        checkOutput("t4 busy after abort", 32'(busy1), 32'd0);
        checkOutput("t4 dut_in after abort", 32'(dut_in1), 32'd0);
        repeat (50) @(negedge clk);
        checkOutput("t4 result kept", 32'(result1), 32'hA7);
        checkOutput("t4 match kept", 32'(match1), 32'd1);
        applyStimulus(1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        checkOutput("t4 start beats abort", 32'(busy1), 32'd1);
        waitDone(100);

        // 5) asynchronous reset mid-sweep
        applyStimulus(0, 8'hA7, 8'hA7, 1'b1, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5 async dut_in", 32'(dut_in1), 32'd0);
        checkOutput("t5 async busy", 32'(busy1), 32'd0);
        checkOutput("t5 async result", 32'(result1), 32'd0);
        checkOutput("t5 async match", 32'(match1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 8'hA7, 8'hA7, 1'b1, 1'b1, 1'b0);
        waitDone(100);

        // 6) N_IN=2 XOR build and SETTLE_CYCLES=3 build with a delayed gate
        @(negedge clk);
        expected2 = 4'h6;
        expected3 = 8'hA7;
        start2    = 1'b1;
        start3    = 1'b1;
        e.res = 8'h06; e.mat = 1'b1; e.when = cycle + 1 + LAT2;
        q2.push_back(e);
        e.res = 8'hA7; e.mat = 1'b1; e.when = cycle + 1 + LAT3;
        q3.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
        start3 = 1'b0;
        checkOutput("t6 u2 busy", 32'(busy2), 32'd1);
        checkOutput("t6 u3 busy", 32'(busy3), 32'd1);
        waitDone(100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
